sdram_init_refresh: RTL

- Housekeeping stage directly upstream of the SDRAM command path on the Zorro III RAM card.
- Runs the power-up initialisation sequence on both chip selects, then generates periodic auto-refresh with a req/ack handshake.
- The SDRAM cycle controller grants the command bus to this block between Z3 cycles.
- While `cmd_own` is high, the top-level muxes this block's command outputs onto CS_n/RAS_n/CAS_n/WE_n/BA/MA/CKE.

---
 rtl/sdram_init_refresh_if.sv | 28 ++
 rtl/sdram_init_refresh.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sdram_init_refresh_if.sv
// sdram_init_refresh_if: SDRAM command bus and refresh req/ack handshake between
// sdram_init_refresh (master) and the SDRAM cycle controller (slave).
interface sdram_init_refresh_if;
  logic        refresh_ack;
  logic        cmd_own;
  logic        init_done;
  logic        refresh_req;
  logic        refresh_done;
  logic        CKE;
  logic [1:0]  CS_n;
  logic        RAS_n;
  logic        CAS_n;
  logic        WE_n;
  logic [1:0]  BA;
  logic [12:0] MA;

  modport master (
    input  refresh_ack,
    output cmd_own, init_done, refresh_req, refresh_done,
    output CKE, CS_n, RAS_n, CAS_n, WE_n, BA, MA
  );

  modport slave (
    output refresh_ack,
    input  cmd_own, init_done, refresh_req, refresh_done,
    input  CKE, CS_n, RAS_n, CAS_n, WE_n, BA, MA
  );
endinterface

// File: rtl/sdram_init_refresh.sv
// sdram_init_refresh: SDRAM power-up init on both chip selects, then periodic auto-refresh.
// Optional macro SDRAM_REFRESH_DEBT_EN: 3-bit saturating refresh debt instead of a pending flag.
module sdram_init_refresh #(
  parameter int unsigned INIT_WAIT        = 2500,
  parameter int unsigned REFRESH_INTERVAL = 195,
  parameter int unsigned T_RP             = 1,
  parameter int unsigned T_RFC            = 2,
  parameter int unsigned T_MRD            = 2,
  parameter logic [12:0] MODE_REG         = 13'h020
) (
  input logic                  CLK,
  input logic                  RESET_n,
  sdram_init_refresh_if.master bus
);
  localparam int unsigned M1   = (INIT_WAIT > T_RP) ? INIT_WAIT : T_RP;
  localparam int unsigned M2   = (M1 > T_RFC) ? M1 : T_RFC;
  localparam int unsigned CMAX = (M2 > T_MRD) ? M2 : T_MRD;
  localparam int unsigned CWR  = $clog2(CMAX + 1);
  localparam int unsigned CW   = (CWR < 1) ? 1 : CWR;
  localparam int unsigned IWR  = $clog2(REFRESH_INTERVAL + 1);
  localparam int unsigned IW   = (IWR < 1) ? 1 : IWR;
`ifdef SDRAM_REFRESH_DEBT_EN
  localparam int unsigned PW   = 3;
`else
  localparam int unsigned PW   = 1;
`endif

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_PRECHARGE, S_PRE_WAIT, S_INIT_REF, S_INIT_RFC,
    S_LOAD_MODE, S_MRD_WAIT, S_IDLE, S_REFRESH, S_RFC_WAIT
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            ref_cnt;
  logic            iv_run;
  logic [IW-1:0]   iv_cnt;
  logic [PW-1:0]   pending;
  logic [PW-1:0]   pending_d;
  logic            wrap;
  logic            take;
  logic            done;

  // An ack in the same cycle as a wrap is honoured even though refresh_req is still low.
  always_comb begin
    wrap = iv_run && (iv_cnt == IW'(REFRESH_INTERVAL - 1));
    take = (state == S_IDLE) && bus.refresh_ack && ((pending != '0) || wrap);
    done = (state == S_RFC_WAIT) && (cnt >= CW'(T_RFC));
`ifdef SDRAM_REFRESH_DEBT_EN
    pending_d = pending;
    if (wrap && !done && (pending != '1))
      pending_d = pending + PW'(1);
    else if (done && !wrap && (pending != '0))
      pending_d = pending - PW'(1);
`else
    pending_d = pending;
    if (wrap)
      pending_d = 1'b1;
    else if (done)
      pending_d = 1'b0;
`endif
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state            <= S_INIT_WAIT;
      cnt              <= '0;
      ref_cnt          <= 1'b0;
      iv_run           <= 1'b0;
      iv_cnt           <= '0;
      pending          <= '0;
      bus.CKE          <= 1'b0;
      bus.CS_n         <= '1;
      bus.RAS_n        <= 1'b1;
      bus.CAS_n        <= 1'b1;
      bus.WE_n         <= 1'b1;
      bus.BA           <= '0;
      bus.MA           <= '0;
      bus.cmd_own      <= 1'b1;
      bus.init_done    <= 1'b0;
      bus.refresh_req  <= 1'b0;
      bus.refresh_done <= 1'b0;
    end else begin
      bus.CKE          <= 1'b1;
      bus.CS_n         <= '1;
      bus.RAS_n        <= 1'b1;
      bus.CAS_n        <= 1'b1;
      bus.WE_n         <= 1'b1;
      bus.BA           <= '0;
      bus.MA           <= '0;
      bus.refresh_done <= 1'b0;
      pending          <= pending_d;
      bus.refresh_req  <= (pending_d != '0);
      if (iv_run)
        iv_cnt <= wrap ? '0 : iv_cnt + IW'(1);

      // Outputs are registered alongside the state, so each branch drives the command for the state it enters.
      case (state)
        S_INIT_WAIT: begin
          if (cnt == CW'(INIT_WAIT)) begin
            state      <= S_PRECHARGE;
            bus.CS_n   <= '0;
            bus.RAS_n  <= 1'b0;
            bus.WE_n   <= 1'b0;
            bus.MA     <= 13'h0400;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_PRECHARGE: begin
          state <= S_PRE_WAIT;
          cnt   <= CW'(1);
        end
        S_PRE_WAIT: begin
          if (cnt >= CW'(T_RP)) begin
            state     <= S_INIT_REF;
            bus.CS_n  <= '0;
            bus.RAS_n <= 1'b0;
            bus.CAS_n <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_INIT_REF: begin
          state <= S_INIT_RFC;
          cnt   <= CW'(1);
        end
        S_INIT_RFC: begin
          if (cnt >= CW'(T_RFC)) begin
            bus.CS_n  <= '0;
            bus.RAS_n <= 1'b0;
            bus.CAS_n <= 1'b0;
            if (!ref_cnt) begin
              ref_cnt <= 1'b1;
              state   <= S_INIT_REF;
            end else begin
              state    <= S_LOAD_MODE;
              bus.WE_n <= 1'b0;
              bus.MA   <= MODE_REG;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_LOAD_MODE: begin
          state <= S_MRD_WAIT;
          cnt   <= CW'(1);
        end
        S_MRD_WAIT: begin
          if (cnt >= CW'(T_MRD)) begin
            state         <= S_IDLE;
            bus.init_done <= 1'b1;
            bus.cmd_own   <= 1'b0;
            iv_run        <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_IDLE: begin
          if (take) begin
            state       <= S_REFRESH;
            bus.cmd_own <= 1'b1;
            bus.CS_n    <= '0;
            bus.RAS_n   <= 1'b0;
            bus.CAS_n   <= 1'b0;
          end
        end
        S_REFRESH: begin
          state <= S_RFC_WAIT;
          cnt   <= CW'(1);
        end
        S_RFC_WAIT: begin
          if (done) begin
            state            <= S_IDLE;
            bus.refresh_done <= 1'b1;
            bus.cmd_own      <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= S_INIT_WAIT;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule
